dmem_store_queue: RTL and testbench

Store-side counterpart to the MIPS150 load path: accepts SB/SH/SW requests from the M stage, aligns store data onto DMEM byte lanes with per-byte write enables, and buffers them in a small FIFO. Entries drain to DMEM port A whenever a load does not need the port. The block also flags loads that hit a pending store word, so the core can stall them.

---
 rtl/dmem_store_queue.sv | 149 ++++++++++++++
 tb/tb_dmem_store_queue.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_queue.sv
// dmem_store_queue
//   Store buffer between the M stage and DMEM port A. Incoming SB/SH/SW
//   requests are aligned onto little-endian byte lanes with per-byte write
//   enables and queued in a DEPTH-entry FIFO. The head entry drains to DMEM
//   whenever no load needs the port, or whenever the active load hits a
//   pending store word (ld_hazard); in that case the core stalls the load.
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   st_valid/st_ready   store request handshake (ready = not full)
//   st_addr/st_data     store byte address and rt value
//   st_size             00 byte, 01 half, 10 word, 11 illegal
//   st_misaligned       one-cycle pulse after a dropped (misaligned) store
//   ld_active/ld_addr   load using port A this cycle and its byte address
//   ld_hazard           load word address matches a queued entry
//   dmem_we/addr/din    DMEM port A write enables, word address, data
//   empty/count         FIFO occupancy
module dmem_store_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [31:0]              st_data,
  input  logic [1:0]               st_size,
  output logic                     st_misaligned,
  input  logic                     ld_active,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hazard,
  output logic [3:0]               dmem_we,
  output logic [ADDR_W-3:0]        dmem_addr,
  output logic [31:0]              dmem_din,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b1;
      2'b01:   return ~off[0];
      2'b10:   return (off == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_we(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_din(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  logic [ADDR_W-3:0] addr_mem [DEPTH];
  logic [3:0]        we_mem   [DEPTH];
  logic [31:0]       din_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mis_q, mis_d;

  logic st_aligned, st_fire, push, pop, ld_hit;

  assign st_ready   = (count_q != FULL);
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign st_misaligned = mis_q;

  assign st_aligned = is_aligned(st_size, st_addr[1:0]);
  assign st_fire    = st_valid && st_ready;
  assign push       = st_fire && st_aligned;

  // Only slots between the read pointer and read pointer + count hold live
  // entries; stale slots must never raise a hazard.
  always_comb begin
    logic [PTR_W-1:0] off;
    ld_hit = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      off = PTR_W'(j) - rd_ptr_q;
      if ((CNT_W'(off) < count_q) &&
          ((ld_addr >> 2) == ADDR_W'(addr_mem[j])))
        ld_hit = 1'b1;
    end
  end

  assign ld_hazard = ld_active && ld_hit;

  // A hazarding load yields the port to the drain, so the matching store
  // always retires and the retried load sees committed data.
  assign pop       = !empty && (!ld_active || ld_hazard);
  assign dmem_we   = pop ? we_mem[rd_ptr_q] : 4'b0000;
  assign dmem_addr = addr_mem[rd_ptr_q];
  assign dmem_din  = din_mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mis_d    = st_fire && !st_aligned;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // ---- enqueue / dequeue register boundary ----
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= st_addr[ADDR_W-1:2];
      we_mem[wr_ptr_q]   <= lane_we(st_size, st_addr[1:0]);
      din_mem[wr_ptr_q]  <= lane_din(st_size, st_data);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mis_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mis_q    <= mis_d;
    end
  end

endmodule

// File: tb/tb_dmem_store_queue.sv
// Testbench for dmem_store_queue: directed steps with a scoreboard of
// expected DMEM writes, compared whenever the DUT drives dmem_we.
module tb_dmem_store_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [1:0]        st_size;
  logic              st_misaligned;
  logic              ld_active;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hazard;
  logic [3:0]        dmem_we;
  logic [ADDR_W-3:0] dmem_addr;
  logic [31:0]       dmem_din;
  logic              empty;
  logic [$clog2(DEPTH):0] count;

  dmem_store_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_size(st_size), .st_misaligned(st_misaligned),
    .ld_active(ld_active), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_din(dmem_din),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]        we;
    logic [ADDR_W-3:0] addr;
    logic [31:0]       din;
  } sb_t;

  sb_t sb[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  bit  mon_en   = 1'b0;
  int  exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Byte-lane model: lane k is written when it falls in the naturally
  // aligned group of nb bytes that contains the address; the data is the
  // low nb bytes of the register replicated across the word.
  task automatic expect_push(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                             input logic [1:0] sz);
    sb_t e;
    int nb;
    int off;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = int'(a[1:0]);
    e.addr = a[ADDR_W-1:2];
    for (int k = 0; k < 4; k++) begin
      e.we[k]        = ((k / nb) == (off / nb));
      e.din[8*k +: 8] = d[8*(k % nb) +: 8];
    end
    sb.push_back(e);
  endtask

  task automatic drive_st(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                          input logic [1:0] sz);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = sz;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en && dmem_we !== 4'b0000) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_write", 32'(dmem_we), 32'h0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_we", 32'(dmem_we), 32'(e.we));
        chk("sb_addr", 32'(dmem_addr), 32'(e.addr));
        chk("sb_din", dmem_din, e.din);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    ld_active = 1'b0; ld_addr = '0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_we", 32'(dmem_we), 32'h0);
    chk("rst_hazard", 32'(ld_hazard), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_mis", 32'(st_misaligned), 32'd0);
    tick();
    rst = 1'b1;
    mon_en = 1'b1;

    // SB to lane 2
    drive_st(14'h006, 32'h0000_00A5, 2'b00);
    expect_push(14'h006, 32'h0000_00A5, 2'b00);
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    chk("sb_lat_we", 32'(dmem_we), 32'h4);
    chk("sb_lat_addr", 32'(dmem_addr), 32'h001);
    chk("sb_lat_din", dmem_din, 32'hA5A5_A5A5);
    chk("sb_lat_count", 32'(count), 32'd1);
    tick();
    @(negedge clk);
    chk("sb_empty_after", 32'(empty), 32'd1);
    tick();

    // SH upper half then SW back to back
    drive_st(14'h00A, 32'h1234_BEEF, 2'b01);
    expect_push(14'h00A, 32'h1234_BEEF, 2'b01);
    tick();
    drive_st(14'h010, 32'hDEAD_BEEF, 2'b10);
    expect_push(14'h010, 32'hDEAD_BEEF, 2'b10);
    @(negedge clk);
    chk("sh_we", 32'(dmem_we), 32'hC);
    chk("sh_addr", 32'(dmem_addr), 32'h002);
    chk("sh_din", dmem_din, 32'hBEEF_BEEF);
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    chk("sw_we", 32'(dmem_we), 32'hF);
    chk("sw_addr", 32'(dmem_addr), 32'h004);
    chk("sw_din", dmem_din, 32'hDEAD_BEEF);
    tick();

    // Fill while a non-matching load holds the port
    ld_active = 1'b1;
    ld_addr   = 14'h100;
    for (int i = 0; i < 5; i++) begin
      drive_st(14'(14'h040 + 4*i), 32'h1000_0000 + 32'(i), 2'b10);
      @(negedge clk);
      chk("fill_ready", 32'(st_ready), (i < 4) ? 32'd1 : 32'd0);
      chk("fill_we", 32'(dmem_we), 32'h0);
      if (i < 4) expect_push(14'(14'h040 + 4*i), 32'h1000_0000 + 32'(i), 2'b10);
      tick();
    end
    st_valid = 1'b0;
    @(negedge clk);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(st_ready), 32'd0);
    chk("full_hazard", 32'(ld_hazard), 32'd0);
    tick();
    ld_active = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain_we", 32'(dmem_we), 32'hF);
      chk("drain_count", 32'(count), 32'(4 - k));
      if (k == 0) chk("full_pop_ready", 32'(st_ready), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("drained_count", 32'(count), 32'd0);
    tick();

    // Load hazard against a queued word
    ld_active = 1'b1;
    ld_addr   = 14'h020;
    drive_st(14'h020, 32'hCAFE_F00D, 2'b10);
    expect_push(14'h020, 32'hCAFE_F00D, 2'b10);
    @(negedge clk);
    chk("hz_same_cycle", 32'(ld_hazard), 32'd0);
    tick();
    st_valid = 1'b0;
    ld_addr  = 14'h022;
    @(negedge clk);
    chk("hz_hit", 32'(ld_hazard), 32'd1);
    chk("hz_we", 32'(dmem_we), 32'hF);
    chk("hz_addr", 32'(dmem_addr), 32'h008);
    tick();
    @(negedge clk);
    chk("hz_clear", 32'(ld_hazard), 32'd0);
    chk("hz_clear_we", 32'(dmem_we), 32'h0);
    chk("hz_clear_count", 32'(count), 32'd0);
    tick();
    ld_active = 1'b0;

    // Misaligned stores
    drive_st(14'h001, 32'h1111_2222, 2'b01);
    @(negedge clk);
    chk("mis0_pre", 32'(st_misaligned), 32'd0);
    tick();
    drive_st(14'h006, 32'h3333_4444, 2'b10);
    @(negedge clk);
    chk("mis_sh", 32'(st_misaligned), 32'd1);
    chk("mis_sh_count", 32'(count), 32'd0);
    chk("mis_sh_we", 32'(dmem_we), 32'h0);
    tick();
    drive_st(14'h008, 32'h5555_6666, 2'b11);
    @(negedge clk);
    chk("mis_sw", 32'(st_misaligned), 32'd1);
    chk("mis_sw_count", 32'(count), 32'd0);
    chk("mis_sw_we", 32'(dmem_we), 32'h0);
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    chk("mis_sz11", 32'(st_misaligned), 32'd1);
    chk("mis_sz11_count", 32'(count), 32'd0);
    chk("mis_sz11_we", 32'(dmem_we), 32'h0);
    tick();
    @(negedge clk);
    chk("mis_fall", 32'(st_misaligned), 32'd0);
    tick();

    // Reset mid-drain discards queued entries
    ld_active = 1'b1;
    ld_addr   = 14'h100;
    for (int i = 0; i < 3; i++) begin
      drive_st(14'(14'h080 + 4*i), 32'hA000_0000 + 32'(i), 2'b10);
      expect_push(14'(14'h080 + 4*i), 32'hA000_0000 + 32'(i), 2'b10);
      tick();
    end
    drive_st(14'h0C0, 32'hBAD0_BAD0, 2'b10);
    ld_active = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_we", 32'(dmem_we), 32'hF);
    chk("rstmid_count", 32'(count), 32'd3);
    tick();
    rst = 1'b1;
    st_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rstmid_after_count", 32'(count), 32'd0);
    chk("rstmid_after_we", 32'(dmem_we), 32'h0);
    chk("rstmid_after_empty", 32'(empty), 32'd1);
    chk("rstmid_after_ready", 32'(st_ready), 32'd1);
    tick();

    // Pointer wrap-around with mixed sizes and intermittent load stalls
    exp_cnt = 0;
    ld_addr = 14'h3000;
    for (int i = 0; i < 2*DEPTH + 1; i++) begin
      logic [1:0]        sz;
      logic [ADDR_W-1:0] a;
      logic [31:0]       d;
      sz = 2'(i % 3);
      a  = 14'(14'h100 + 4*i);
      if (sz == 2'd0) a[1:0] = 2'(i % 4);
      if (sz == 2'd1) a[1:0] = 2'(2 * (i % 2));
      d  = $urandom;
      ld_active = ((i % 3) == 0);
      drive_st(a, d, sz);
      expect_push(a, d, sz);
      @(negedge clk);
      chk("wrap_count", 32'(count), 32'(exp_cnt));
      chk("wrap_ready", 32'(st_ready), 32'd1);
      exp_cnt = exp_cnt + 1 - ((exp_cnt > 0 && !ld_active) ? 1 : 0);
      tick();
    end
    st_valid  = 1'b0;
    ld_active = 1'b0;
    for (int k = 0; k < 2*DEPTH && exp_cnt > 0; k++) begin
      @(negedge clk);
      chk("wrap_drain_count", 32'(count), 32'(exp_cnt));
      exp_cnt--;
      tick();
    end
    @(negedge clk);
    chk("wrap_final_count", 32'(count), 32'd0);
    chk("wrap_sb_empty", 32'(sb.size()), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
